seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Scans one digit per slot and decodes each 4-bit nibble to segments with an optional full-hex F glyph.
- Adds leading-zero suppression, per-digit blank and decimal point, anti-ghost blanking and tear-free frame-synchronous value updates.
- Sits between the datapath that produces the display value and the board's segment/anode pins.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_lz_mask.sv | 27 ++
 rtl/seg7_scan_driver.sv | 114 +++++++++++
 tb/tb_seg7_scan_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph table and decode helper for the 7-segment scan driver.
// Segments are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_F     = 7'b0001110;

  localparam seg7_t GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, SEG_F
  };

  // Legacy boards rendered nibble F as an empty digit.
  function automatic seg7_t seg7_decode(input logic [3:0] nibble, input logic hex_f);
    if (nibble == 4'hF && !hex_f) return SEG_BLANK;
    return GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Per-digit blank mask: forced blanks plus leading-zero suppression.
// Digit 0 is never suppressed so a zero value still shows "0".
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] nibbles,
  input  logic [DIGITS-1:0]   blank,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   mask
);

  logic zero_above;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    mask       = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (nibbles[4*k +: 4] == 4'h0);
      mask[k]    = blank[k] | (lz_en & zero_above & (k > 0));
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous,
// tear-free value updates and anti-ghost anode blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 8,
  parameter int HEX_F     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                lz_en,
  input  logic                load,
  output logic                upd_ack,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   an_out,
  output logic                frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc, presc_n;
  logic [IW-1:0]       idx, idx_n;
  logic                slot_wrap, frame_wrap;

  logic [4*DIGITS-1:0] stg_value, shd_value;
  logic [DIGITS-1:0]   stg_dp, shd_dp;
  logic [DIGITS-1:0]   stg_blank, shd_blank;
  logic                pending;

  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   an_n;
  logic [3:0]          cur_nib;
  seg7_t               cur_seg;

  seg7_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
    .nibbles (shd_value),
    .blank   (shd_blank),
    .lz_en   (lz_en),
    .mask    (blank_mask)
  );

  always_comb begin
    slot_wrap  = (presc == PW'(SCAN_DIV - 1));
    frame_wrap = slot_wrap && (idx == IW'(DIGITS - 1));
    presc_n    = slot_wrap ? '0 : presc + 1'b1;
    idx_n      = idx;
    if (slot_wrap) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

    // Anodes are computed from the next counter state so the registered pins
    // line up exactly with the prescaler phase, including the blanking window.
    an_n = '1;
    if (presc_n >= PW'(BLANK_CYC)) an_n[idx_n] = 1'b0;

    cur_nib = shd_value[4*idx +: 4];
    cur_seg = blank_mask[idx] ? SEG_BLANK : seg7_decode(cur_nib, HEX_F != 0);
  end

  // NOTE: staging and shadow are ordinary flops with a reset so the display
  // comes up showing zeros and a pending update never survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      stg_value  <= '0;
      stg_dp     <= '0;
      stg_blank  <= '0;
      shd_value  <= '0;
      shd_dp     <= '0;
      shd_blank  <= '0;
      pending    <= 1'b0;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= SEG_BLANK;
      dp_out     <= 1'b1;
      an_out     <= '1;
    end else begin
      // NOTE: non-blocking assignments make every right-hand side read the
      // pre-edge state, so a load on the boundary cycle hands the shadow the
      // old staging while the new data waits for the next frame.
      presc      <= presc_n;
      idx        <= idx_n;
      frame_done <= frame_wrap;
      upd_ack    <= frame_wrap & pending;

      if (frame_wrap && pending) begin
        shd_value <= stg_value;
        shd_dp    <= stg_dp;
        shd_blank <= stg_blank;
      end

      if (load) begin
        stg_value <= value;
        stg_dp    <= dp_in;
        stg_blank <= blank_in;
        pending   <= 1'b1;
      end else if (frame_wrap) begin
        pending   <= 1'b0;
      end

      // Segments lag idx by one cycle; the blanking window hides the change.
      seg_out <= cur_seg;
      dp_out  <= ~(shd_dp[idx] & ~shd_blank[idx]);
      an_out  <= an_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: reset values, glyph vectors,
// frame-boundary load corner cases, async reset and randomized traffic.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic        upd_ack;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .HEX_F(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load       (load),
    .upd_ack    (upd_ack),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference glyphs, active-low g..a.
  function automatic logic [6:0] ref_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b0100111;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input int k, input logic [15:0] v,
                                           input logic [3:0] bl, input bit lz);
    if (bl[k]) return 7'h7F;
    if (lz && k > 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
    return ref_glyph(v[4*k +: 4]);
  endfunction

  // Reference model: time since reset (n = clock edges) gives slot and phase.
  int          n;
  logic [15:0] st_v, sh_v;
  logic [3:0]  st_dp, sh_dp, st_bl, sh_bl;
  bit          pend;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd, exp_ack;
  logic [3:0]  exp_an;

  task automatic model_reset();
    n = 0; pend = 0;
    st_v = '0; sh_v = '0; st_dp = '0; sh_dp = '0; st_bl = '0; sh_bl = '0;
  endtask

  task automatic model_step(input bit ld, input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input bit lz);
    int slot;
    slot    = (n / SCAN_DIV) % DIGITS;
    exp_seg = ref_digit(slot, sh_v, sh_bl, lz);
    exp_dp  = ~(sh_dp[slot] & ~sh_bl[slot]);
    n++;
    exp_fd  = (n % FRAME == 0);
    exp_ack = exp_fd && pend;
    if (exp_ack) begin
      sh_v = st_v; sh_dp = st_dp; sh_bl = st_bl; pend = 0;
    end
    if (ld) begin
      st_v = v; st_dp = dp; st_bl = bl; pend = 1;
    end
    slot   = (n / SCAN_DIV) % DIGITS;
    exp_an = ((n % SCAN_DIV) >= BLANK_CYC) ? ~(4'b0001 << slot) : 4'hF;
  endtask

  logic [15:0] cur_v = '0;
  logic [3:0]  cur_dp = '0, cur_bl = '0;
  bit          cur_lz = 0;

  task automatic tick(input bit ld);
    load = ld; value = cur_v; dp_in = cur_dp; blank_in = cur_bl; lz_en = cur_lz;
    @(posedge clk);
    model_step(ld, cur_v, cur_dp, cur_bl, cur_lz);
    @(negedge clk);
    check("seg_out", seg_out, exp_seg);
    check("dp_out", dp_out, exp_dp);
    check("an_out", an_out, exp_an);
    check("frame_done", frame_done, exp_fd);
    check("upd_ack", upd_ack, exp_ack);
    load = 1'b0;
  endtask

  logic [6:0] cap_seg [4];
  logic [3:0] cap_dp;

  // Runs one full frame, recording what each digit shows while its anode is on.
  task automatic capture_frame();
    for (int k = 0; k < 4; k++) cap_seg[k] = 'x;
    cap_dp = 'x;
    repeat (FRAME) begin
      tick(0);
      for (int k = 0; k < 4; k++)
        if (an_out[k] == 1'b0) begin
          cap_seg[k] = seg_out;
          cap_dp[k]  = dp_out;
        end
    end
  endtask

  task automatic wait_ack(input string name);
    bit seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      tick(0);
      if (upd_ack) seen = 1;
    end
    check(name, seen, 1);
  endtask

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpo;    // active-low dp_out per digit
  } vec_t;

  vec_t vecs [7];

  initial begin
    watchdog_guard();
  end

  task automatic watchdog_guard();
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  endtask

  initial begin
    int fdc, acks;
    vecs[0] = '{16'h0A3F, 4'b0000, 4'b0000, 1'b0,
                {7'b1000000, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1111};
    vecs[1] = '{16'h0005, 4'b0000, 4'b0000, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h1234, 4'b0100, 4'b0001, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'h7F}, 4'b1011};
    vecs[4] = '{16'h89BC, 4'b0000, 4'b0000, 1'b1,
                {7'b0000000, 7'b0010000, 7'b0000011, 7'b0100111}, 4'b1111};
    vecs[5] = '{16'h67DE, 4'b0000, 4'b0000, 1'b0,
                {7'b0000010, 7'b1111000, 7'b0100001, 7'b0000110}, 4'b1111};
    vecs[6] = '{16'h0050, 4'b1111, 4'b0000, 1'b1,
                {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'b0000};

    // Reset values while rst_n is held low.
    #12;
    check("rst_seg", seg_out, 7'h7F);
    check("rst_dp", dp_out, 1'b1);
    check("rst_an", an_out, 4'hF);
    check("rst_ack", upd_ack, 1'b0);
    check("rst_fd", frame_done, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle scan: zeros everywhere, frame_done every FRAME cycles.
    fdc = 0;
    repeat (2 * FRAME) begin
      tick(0);
      fdc += int'(frame_done);
    end
    check("frame_done_count", fdc, 2);

    // Table-driven glyph / suppression / dp vectors.
    for (int i = 0; i < 7; i++) begin
      cur_v = vecs[i].v; cur_dp = vecs[i].dp; cur_bl = vecs[i].bl; cur_lz = vecs[i].lz;
      tick(1);
      wait_ack($sformatf("v%0d_ack", i));
      capture_frame();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("v%0d_seg%0d", i, k), cap_seg[k], vecs[i].segs[7*k +: 7]);
        check($sformatf("v%0d_dp%0d", i, k), cap_dp[k], vecs[i].dpo[k]);
      end
    end

    // Two loads in a frame, then a load on the boundary cycle itself.
    cur_dp = '0; cur_bl = '0; cur_lz = 0;
    while (n % FRAME != 2) tick(0);
    cur_v = 16'h1111; tick(1);
    repeat (3) tick(0);
    cur_v = 16'h2222; tick(1);
    while ((n + 1) % FRAME != 0) tick(0);
    cur_v = 16'h3333; tick(1);
    check("boundary_ack", upd_ack, 1'b1);
    capture_frame();
    for (int k = 0; k < 4; k++) check($sformatf("last_wins_seg%0d", k), cap_seg[k], 7'b0100100);
    check("boundary_data_ack", upd_ack, 1'b1);
    capture_frame();
    for (int k = 0; k < 4; k++) check($sformatf("boundary_seg%0d", k), cap_seg[k], 7'b0110000);

    // Asynchronous reset mid-slot with an update pending.
    cur_v = 16'hABCD; tick(1);
    while (n % SCAN_DIV != 2) tick(0);
    check("pre_reset_an_active", an_out != 4'hF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg_out, 7'h7F);
    check("async_rst_dp", dp_out, 1'b1);
    check("async_rst_an", an_out, 4'hF);
    check("async_rst_ack", upd_ack, 1'b0);
    check("async_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(0);
    check("post_reset_seg", seg_out, 7'b1000000);
    acks = 0;
    repeat (3 * FRAME) begin
      tick(0);
      acks += int'(upd_ack);
    end
    check("no_ack_after_reset", acks, 0);

    // Randomized traffic against the model.
    repeat (1500) begin
      bit ld;
      ld = ($urandom_range(0, 7) == 0);
      if (ld) begin
        cur_v  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
        cur_dp = 4'($urandom_range(0, 15));
        cur_bl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      if ($urandom_range(0, 31) == 0) cur_lz = ~cur_lz;
      tick(ld);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
